// File: rtl/conv_weight_loader.sv
// rtl/conv_weight_loader.sv - weight/bias loader feeding the convolution core from a packed parameter stream
// One bias word, then KPOS weight beats per PE array, broadcast on a shared bus with a one-hot strobe.
module conv_weight_loader #(
    parameter int WEIGHT_WIDTH    = 16,
    parameter int PE_CORE_NUM     = 16,
    parameter int PE_NUM_PRE_CORE = 3,
    parameter int BIAS_WIDTH      = 32,
    parameter int ARRAY_NUM       = 8,
    localparam int BUS_W          = WEIGHT_WIDTH * PE_CORE_NUM
) (
    input  logic                            DSP_clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [3:0]                      array_count,
    input  logic [BUS_W-1:0]                in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [BUS_W-1:0]                weight,
    output logic [ARRAY_NUM-1:0]            weight_valid,
    output logic [BIAS_WIDTH*ARRAY_NUM-1:0] bias,
    output logic                            bias_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int KPOS       = PE_NUM_PRE_CORE * PE_NUM_PRE_CORE;
    localparam int BIAS_BUS_W = BIAS_WIDTH * ARRAY_NUM;
    localparam int AW         = (ARRAY_NUM > 1) ? $clog2(ARRAY_NUM) : 1;
    localparam int KW         = (KPOS > 1) ? $clog2(KPOS) : 1;

    localparam logic [3:0]    MAX_COUNT = 4'(ARRAY_NUM);
    localparam logic [AW-1:0] ARR_MAX   = AW'(ARRAY_NUM - 1);
    localparam logic [KW-1:0] KPOS_LAST = KW'(KPOS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BIAS,
        S_WEIGHT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           arr_q, arr_d;
    logic [AW-1:0]           last_arr_q, last_arr_d;
    logic [KW-1:0]           kpos_q, kpos_d;
    logic [BUS_W-1:0]        weight_q, weight_d;
    logic [ARRAY_NUM-1:0]    weight_valid_q, weight_valid_d;
    logic [BIAS_BUS_W-1:0]   bias_q, bias_d;
    logic                    bias_valid_q, bias_valid_d;
    logic                    handshake;

    // in_ready is decoded from the state register only, never from in_valid.
    assign in_ready  = (state_q == S_BIAS) || (state_q == S_WEIGHT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign handshake = in_valid & in_ready;

    assign weight       = weight_q;
    assign weight_valid = weight_valid_q;
    assign bias         = bias_q;
    assign bias_valid   = bias_valid_q;

    always_comb begin
        state_d        = state_q;
        arr_d          = arr_q;
        last_arr_d     = last_arr_q;
        kpos_d         = kpos_q;
        weight_d       = weight_q;
        bias_d         = bias_q;
        weight_valid_d = '0;
        bias_valid_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A count of zero or beyond the array total loads every array.
                    if ((array_count == 4'd0) || (array_count > MAX_COUNT)) begin
                        last_arr_d = ARR_MAX;
                    end else begin
                        last_arr_d = AW'(array_count - 4'd1);
                    end
                    arr_d   = '0;
                    kpos_d  = '0;
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                if (handshake) begin
                    bias_d       = in_data[BIAS_BUS_W-1:0];
                    bias_valid_d = 1'b1;
                    state_d      = S_WEIGHT;
                end
            end
            S_WEIGHT: begin
                if (handshake) begin
                    weight_d       = in_data;
                    weight_valid_d = ARRAY_NUM'(1) << arr_q;
                    if (kpos_q == KPOS_LAST) begin
                        kpos_d = '0;
                        if (arr_q == last_arr_q) begin
                            state_d = S_DONE;
                        end else begin
                            arr_d = arr_q + AW'(1);
                        end
                    end else begin
                        kpos_d = kpos_q + KW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge DSP_clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            arr_q          <= '0;
            last_arr_q     <= '0;
            kpos_q         <= '0;
            weight_q       <= '0;
            weight_valid_q <= '0;
            bias_q         <= '0;
            bias_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            arr_q          <= arr_d;
            last_arr_q     <= last_arr_d;
            kpos_q         <= kpos_d;
            weight_q       <= weight_d;
            weight_valid_q <= weight_valid_d;
            bias_q         <= bias_d;
            bias_valid_q   <= bias_valid_d;
        end
    end

endmodule

// File: tb/tb_conv_weight_loader.sv
// tb/tb_conv_weight_loader.sv - scoreboard bench for conv_weight_loader
// Expected strobes are queued as each word is offered and compared one cycle later.
module tb_conv_weight_loader;

    localparam int BUS_W = 256;
    localparam int AN    = 8;
    localparam int KPOS  = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        array_count;
    logic [BUS_W-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [BUS_W-1:0]  weight;
    logic [AN-1:0]     weight_valid;
    logic [BUS_W-1:0]  bias;
    logic              bias_valid;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    conv_weight_loader dut (
        .DSP_clk      (clk),
        .rst          (rst),
        .start        (start),
        .array_count  (array_count),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .weight       (weight),
        .weight_valid (weight_valid),
        .bias         (bias),
        .bias_valid   (bias_valid),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [AN-1:0]    wv;
        logic             bv;
        logic             dn;
        logic [BUS_W-1:0] w;
        logic [BUS_W-1:0] b;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_err    = 0;
    int               base     = 0;
    logic [BUS_W-1:0] m_weight = '0;
    logic [BUS_W-1:0] m_bias   = '0;

    function automatic logic [BUS_W-1:0] mk_word(input int b, input int k);
        return {8{32'(b * 1000 + k)}};
    endfunction

    // Runs one load from start to the IDLE cycle after done; call at a negedge.
    task automatic do_load(input int acnt, input int nexp, input int gap,
                           input int busy_start, input int b2b_cnt);
        int   total;
        int   cnt;
        logic v;
        logic exp_rdy;
        exp_t e;
        exp_t o;
        total = 1 + nexp * KPOS;
        cnt   = 0;
        base++;
        start       = 1'b1;
        array_count = 4'(acnt);
        e.wv = '0; e.bv = 1'b0; e.dn = 1'b0; e.w = m_weight; e.b = m_bias;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        for (int iter = 0; iter <= 1000; iter++) begin
            if (iter == 1000) begin
                n_checks++; n_err++;
                $display("FAIL load_timeout: got no done after %0d cycles, required done within 1000", iter);
                break;
            end
            o = sb_q.pop_front();
            n_checks++;
            if (weight_valid !== o.wv) begin
                n_err++;
                $display("FAIL weight_valid: got %h required %h (words so far %0d)", weight_valid, o.wv, cnt);
            end
            n_checks++;
            if (bias_valid !== o.bv) begin
                n_err++;
                $display("FAIL bias_valid: got %b required %b (words so far %0d)", bias_valid, o.bv, cnt);
            end
            n_checks++;
            if (done !== o.dn) begin
                n_err++;
                $display("FAIL done: got %b required %b (words so far %0d)", done, o.dn, cnt);
            end
            n_checks++;
            if (weight !== o.w) begin
                n_err++;
                $display("FAIL weight: got %h required %h", weight, o.w);
            end
            n_checks++;
            if (bias !== o.b) begin
                n_err++;
                $display("FAIL bias: got %h required %h", bias, o.b);
            end
            exp_rdy = (cnt < total);
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL in_ready: got %b required %b (words so far %0d)", in_ready, exp_rdy, cnt);
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_during_load: got %b required 1", busy);
            end
            if (o.dn) begin
                in_valid = 1'b0;
                if (b2b_cnt != 0) begin
                    start       = 1'b1;
                    array_count = 4'(b2b_cnt);
                end
                break;
            end
            start = (busy_start != 0) && (iter % 20 == 5);
            if (start) array_count = 4'd1;
            v = (cnt < total) && ((gap == 0) || (iter % 2 == 0));
            in_valid = v;
            in_data  = mk_word(base, cnt);
            e.wv = '0; e.bv = 1'b0; e.dn = 1'b0;
            if (v) begin
                if (cnt == 0) begin
                    m_bias = in_data;
                    e.bv   = 1'b1;
                end else begin
                    m_weight = in_data;
                    e.wv     = AN'(1 << ((cnt - 1) / KPOS));
                end
                e.dn = (cnt == total - 1);
                cnt++;
            end
            e.w = m_weight;
            e.b = m_bias;
            sb_q.push_back(e);
            @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, in_ready, done, bias_valid} !== 4'b0000 || weight_valid !== '0) begin
            n_err++;
            $display("FAIL idle_after_done: got busy=%b in_ready=%b done=%b bv=%b wv=%h required all 0",
                     busy, in_ready, done, bias_valid, weight_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; array_count = 4'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, busy, done, bias_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got ready=%b busy=%b done=%b bv=%b required 0000",
                     in_ready, busy, done, bias_valid);
        end
        n_checks++;
        if (weight_valid !== '0 || weight !== '0 || bias !== '0) begin
            n_err++;
            $display("FAIL reset_data: got wv=%h weight=%h bias=%h required 0", weight_valid, weight, bias);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_without_start: got busy=%b in_ready=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_full_load();
        do_load(8, 8, 0, 0, 0);
    endtask

    task automatic test_partial();
        do_load(3, 3, 0, 0, 0);
    endtask

    task automatic test_bubbles();
        do_load(1, 1, 1, 0, 0);
    endtask

    task automatic test_illegal_count();
        do_load(0, 8, 0, 1, 0);
        do_load(12, 8, 1, 1, 0);
    endtask

    task automatic test_reset_mid_load();
        base++;
        start = 1'b1; array_count = 4'd8;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            in_valid = 1'b1;
            in_data  = mk_word(base, k);
            @(negedge clk);
        end
        n_checks++;
        if (weight_valid !== 8'h04 || weight !== mk_word(base, 22)) begin
            n_err++;
            $display("FAIL pre_reset_beat: got wv=%h weight=%h required 04 %h", weight_valid, weight, mk_word(base, 22));
        end
        rst      = 1'b1;
        in_data  = mk_word(base, 23);
        @(negedge clk);
        n_checks++;
        if ({in_ready, busy, done, bias_valid} !== 4'b0000 || weight_valid !== '0 ||
            weight !== '0 || bias !== '0) begin
            n_err++;
            $display("FAIL reset_mid_load: got ready=%b busy=%b done=%b bv=%b wv=%h required all 0",
                     in_ready, busy, done, bias_valid, weight_valid);
        end
        rst = 1'b0; in_valid = 1'b0;
        m_weight = '0; m_bias = '0;
        sb_q.delete();
        do_load(2, 2, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        do_load(2, 2, 0, 0, 1);
        do_load(1, 1, 0, 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000 time units, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_load();
        test_partial();
        test_bubbles();
        test_illegal_count();
        test_reset_mid_load();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
